// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with input FIFO, runtime baud divisor and 1/2 stop bits.
// Optional parity (parity_mode input, PARITY state) is built when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DIV_WIDTH-1:0]        div,
  input  logic                        two_stop,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                  parity_mode,
`endif
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx,
  output logic                        busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_in_ready;

  // Frame engine registers
  state_t               r_state;
  logic                 r_tx;
  logic                 r_busy;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_two_stop;
  logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 w_par_en_n;
  logic                 w_par_bit_n;
`endif

  state_t               w_state_n;
  logic                 w_tx_n;
  logic                 w_busy_n;
  logic [DIV_WIDTH-1:0] w_cnt_n;
  logic [DIV_WIDTH-1:0] w_div_n;
  logic [IDX_W-1:0]     w_bit_idx_n;
  logic                 w_stop_idx_n;
  logic                 w_two_stop_n;
  logic [DATA_BITS-1:0] w_shift_n;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_fifo_ne;
  logic                 w_bit_end;
  logic [DIV_WIDTH-1:0] w_div_eff;
  logic [DATA_BITS-1:0] w_head;
  logic [CNT_W-1:0]     w_count_n;

  // A full FIFO ignores in_valid even when a pop frees a slot on the same edge
  assign w_push    = in_valid && r_in_ready;
  assign w_fifo_ne = (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_div_eff = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
  assign w_bit_end = (r_cnt == r_div - DIV_WIDTH'(1));

  always_comb begin
    w_count_n = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + CNT_W'(1);
      2'b01:   w_count_n = r_count - CNT_W'(1);
      default: w_count_n = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_n;
      r_in_ready <= (w_count_n < CNT_W'(FIFO_DEPTH));
    end
  end

  // Next-state and next-output logic; a pop (load) can happen from IDLE or at the end of STOP
  always_comb begin
    w_state_n    = r_state;
    w_tx_n       = r_tx;
    w_busy_n     = r_busy;
    w_cnt_n      = r_cnt + DIV_WIDTH'(1);
    w_div_n      = r_div;
    w_bit_idx_n  = r_bit_idx;
    w_stop_idx_n = r_stop_idx;
    w_two_stop_n = r_two_stop;
    w_shift_n    = r_shift;
    w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_en_n   = r_par_en;
    w_par_bit_n  = r_par_bit;
`endif

    case (r_state)
      S_IDLE: begin
        w_tx_n   = 1'b1;
        w_busy_n = 1'b0;
        w_cnt_n  = '0;
        w_pop    = w_fifo_ne;
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_n     = '0;
          w_tx_n      = r_shift[0];
          w_shift_n   = r_shift >> 1;
          w_bit_idx_n = '0;
          w_state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_n = '0;
          if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              w_tx_n    = r_par_bit;
              w_state_n = S_PARITY;
            end else begin
              w_tx_n       = 1'b1;
              w_stop_idx_n = 1'b0;
              w_state_n    = S_STOP;
            end
`else
            w_tx_n       = 1'b1;
            w_stop_idx_n = 1'b0;
            w_state_n    = S_STOP;
`endif
          end else begin
            w_tx_n      = r_shift[0];
            w_shift_n   = r_shift >> 1;
            w_bit_idx_n = r_bit_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_n      = '0;
          w_tx_n       = 1'b1;
          w_stop_idx_n = 1'b0;
          w_state_n    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_n = '0;
          if (r_two_stop && !r_stop_idx) begin
            w_stop_idx_n = 1'b1;
          end else if (w_fifo_ne) begin
            w_pop = 1'b1;
          end else begin
            w_tx_n    = 1'b1;
            w_busy_n  = 1'b0;
            w_state_n = S_IDLE;
          end
        end
      end
      default: begin
        w_tx_n    = 1'b1;
        w_busy_n  = 1'b0;
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
    endcase

    // Pop the head word and start its frame on this same edge
    if (w_pop) begin
      w_shift_n    = w_head;
      w_div_n      = w_div_eff;
      w_two_stop_n = two_stop;
      w_tx_n       = 1'b0;
      w_busy_n     = 1'b1;
      w_cnt_n      = '0;
      w_state_n    = S_START;
`ifdef UART_TX_PARITY_EN
      w_par_en_n   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      w_par_bit_n  = (^w_head) ^ (parity_mode == 2'b10);
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_div      <= DIV_WIDTH'(2);
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_two_stop <= 1'b0;
      r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_tx       <= w_tx_n;
      r_busy     <= w_busy_n;
      r_cnt      <= w_cnt_n;
      r_div      <= w_div_n;
      r_bit_idx  <= w_bit_idx_n;
      r_stop_idx <= w_stop_idx_n;
      r_two_stop <= w_two_stop_n;
      r_shift    <= w_shift_n;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= w_par_en_n;
      r_par_bit  <= w_par_bit_n;
`endif
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign in_ready   = r_in_ready;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: directed frame waveforms, backpressure, resets, then random words
// decoded off the tx line and compared against a scoreboard of pushed words.
module tb_uart_tx_param;

  localparam int DB = 8;
  localparam int DW = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [DW-1:0] div;
  logic          two_stop;
`ifdef UART_TX_PARITY_EN
  logic [1:0]    parity_mode;
`endif
  logic [DB-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fifo_count;
  logic          tx;
  logic          busy;

  uart_tx_param #(.DATA_BITS(DB), .FIFO_DEPTH(4), .DIV_WIDTH(DW)) dut (
    .clock(clock),
    .reset(reset),
    .div(div),
    .two_stop(two_stop),
`ifdef UART_TX_PARITY_EN
    .parity_mode(parity_mode),
`endif
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fifo_count(fifo_count),
    .tx(tx),
    .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance to the negedge that follows posedge number e
  task automatic to_neg(input int e);
    do @(negedge clock); while (cyc < e);
  endtask

  // Expected per-clock tx stream, built from the frame format
  bit exp_bits[$];
  task automatic add_frame(input logic [DB-1:0] w, input int d, input bit ts, input logic [1:0] pm);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) b.push_back(w[i]);
    if (PAR_EN && (pm == 2'd1 || pm == 2'd2)) b.push_back((^w) ^ (pm == 2'd2));
    b.push_back(1'b1);
    if (ts) b.push_back(1'b1);
    foreach (b[i]) repeat (d) exp_bits.push_back(b[i]);
  endtask

  // Push words on consecutive edges into an idle DUT and check every clock of the line
  task automatic run_frames(input string tag, input logic [DB-1:0] ws[$], input int d_in,
                            input bit ts, input logic [1:0] pm);
    int n0;
    int de;
    de = (d_in < 2) ? 2 : d_in;
    div = DW'(d_in);
    two_stop = ts;
`ifdef UART_TX_PARITY_EN
    parity_mode = pm;
`endif
    exp_bits.delete();
    foreach (ws[i]) add_frame(ws[i], de, ts, pm);
    n0 = cyc + 1;
    fork
      begin
        foreach (ws[i]) begin
          in_data = ws[i]; in_valid = 1'b1;
          @(posedge clock); #1;
        end
        in_valid = 1'b0;
      end
      begin
        to_neg(n0);
        chk({tag, "_pre_tx"}, 32'(tx), 32'd1);
        chk({tag, "_pre_count"}, 32'(fifo_count), 32'd1);
        foreach (exp_bits[k]) begin
          to_neg(n0 + 1 + k);
          chk({tag, "_tx"}, 32'(tx), 32'(exp_bits[k]));
          chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        to_neg(n0 + 1 + exp_bits.size());
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_tx"}, 32'(tx), 32'd1);
      end
    join
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [DB-1:0] w, input int limit, output bit ok);
    bit rdy;
    in_data = w; in_valid = 1'b1; ok = 1'b0;
    for (int t = 0; t < limit && !ok; t++) begin
      @(negedge clock); rdy = in_ready;
      @(posedge clock); ok = rdy;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk({tag, "_tx"}, 32'(tx), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
    end
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  // Line monitor: decodes frames and matches them against the scoreboard
  bit            mon_en = 1'b0;
  int            m_div  = 2;
  bit            m_ts   = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic [1:0]    m_pm   = 2'd0;
`endif
  logic [DB-1:0] exp_q[$];

  initial begin : monitor
    logic [DB-1:0] mw;
    logic [DB-1:0] ew;
    bit            mok;
`ifdef UART_TX_PARITY_EN
    logic          mp;
`endif
    forever begin
      @(negedge clock);
      if (mon_en && tx === 1'b0) begin
        mok = (busy === 1'b1);
        mw  = '0;
        for (int c = 1; c < m_div; c++) begin
          @(negedge clock);
          if (tx !== 1'b0 || busy !== 1'b1) mok = 1'b0;
        end
        for (int b = 0; b < DB; b++) begin
          for (int c = 0; c < m_div; c++) begin
            @(negedge clock);
            if (c == 0) mw[b] = tx;
            else if (tx !== mw[b]) mok = 1'b0;
          end
        end
`ifdef UART_TX_PARITY_EN
        mp = 1'b0;
        if (m_pm == 2'd1 || m_pm == 2'd2) begin
          for (int c = 0; c < m_div; c++) begin
            @(negedge clock);
            if (c == 0) mp = tx;
            else if (tx !== mp) mok = 1'b0;
          end
        end
`endif
        for (int c = 0; c < m_div * (m_ts ? 2 : 1); c++) begin
          @(negedge clock);
          if (tx !== 1'b1 || busy !== 1'b1) mok = 1'b0;
        end
        chk("mon_frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          ew = exp_q.pop_front();
          chk("mon_word", 32'(mw), 32'(ew));
          chk("mon_timing", 32'(mok), 32'd1);
`ifdef UART_TX_PARITY_EN
          if (m_pm == 2'd1 || m_pm == 2'd2)
            chk("mon_parity", 32'(mp), 32'((^ew) ^ (m_pm == 2'd2)));
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [DB-1:0] ws[$];
    bit            ok;
    int            n0;
    int            nw;
    bit            idle;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; div = DW'(4); two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_mode = 2'd0;
`endif
    repeat (2) @(negedge clock);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    ws = '{8'hA5};             run_frames("single", ws, 4, 1'b0, 2'd0);
    ws = '{8'h00, 8'hFF, 8'h55}; run_frames("b2b", ws, 4, 1'b0, 2'd0);
    ws = '{8'h3C};             run_frames("stop2_clamp", ws, 1, 1'b1, 2'd0);
`ifdef UART_TX_PARITY_EN
    ws = '{8'h07};
    run_frames("par_even", ws, 4, 1'b0, 2'd1);
    run_frames("par_odd", ws, 4, 1'b0, 2'd2);
    run_frames("par_none", ws, 4, 1'b0, 2'd0);
    run_frames("par_11", ws, 4, 1'b0, 2'd3);
    parity_mode = 2'd0;
`endif

    // Reset during data bit 3 of 0x0F with two words queued
    div = DW'(4); two_stop = 1'b0;
    n0 = cyc + 1;
    ws = '{8'h0F, 8'h33, 8'h44};
    foreach (ws[i]) begin
      in_data = ws[i]; in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    to_neg(n0 + 18);
    chk("rmid_pre_tx", 32'(tx), 32'd1);
    chk("rmid_pre_busy", 32'(busy), 32'd1);
    chk("rmid_pre_count", 32'(fifo_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rmid_tx", 32'(tx), 32'd1);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_count", 32'(fifo_count), 32'd0);
    chk("rmid_ready", 32'(in_ready), 32'd1);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    check_quiet("rmid_after", 60);
    @(posedge clock); #1;

    // Backpressure at div=1250, then reset during the second frame's start bit
    div = DW'(1250); two_stop = 1'b0;
    n0 = cyc + 1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(DB'(8'h10 + i), 20000, ok);
          chk("bp_push_ok", 32'(ok), 32'd1);
          chk("bp_push_edge", 32'(cyc), 32'((i < 5) ? n0 + i : n0 + 12502));
        end
      end
      begin
        to_neg(n0 + 5);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_count", 32'(fifo_count), 32'd4);
        to_neg(n0 + 12500);
        chk("bp_last_stop_ready", 32'(in_ready), 32'd0);
        chk("bp_last_stop_count", 32'(fifo_count), 32'd4);
        to_neg(n0 + 12501);
        chk("bp_pop_ready", 32'(in_ready), 32'd1);
        chk("bp_pop_count", 32'(fifo_count), 32'd3);
        chk("bp_pop_tx", 32'(tx), 32'd0);
        chk("bp_pop_busy", 32'(busy), 32'd1);
        to_neg(n0 + 12502);
        chk("bp_refill_ready", 32'(in_ready), 32'd0);
        chk("bp_refill_count", 32'(fifo_count), 32'd4);
      end
    join
    to_neg(n0 + 12503);
    chk("bp_pre_rst_tx", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("bp_rst_tx", 32'(tx), 32'd1);
    chk("bp_rst_busy", 32'(busy), 32'd0);
    chk("bp_rst_count", 32'(fifo_count), 32'd0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    check_quiet("bp_after", 20);
    @(posedge clock); #1;

    // Random words with random divisor, stop bits and push gaps
    mon_en = 1'b1;
    for (int batch = 0; batch < 6; batch++) begin
      div      = DW'($urandom_range(0, 5));
      two_stop = 1'($urandom_range(0, 1));
      m_div    = (div < 2) ? 2 : int'(div);
      m_ts     = two_stop;
`ifdef UART_TX_PARITY_EN
      parity_mode = 2'($urandom_range(0, 3));
      m_pm        = parity_mode;
`endif
      nw = $urandom_range(3, 8);
      for (int i = 0; i < nw; i++) begin
        logic [DB-1:0] w;
        w = DB'($urandom);
        push(w, 2000, ok);
        chk("rnd_push_ok", 32'(ok), 32'd1);
        if (ok) exp_q.push_back(w);
        repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      end
      idle = 1'b0;
      for (int t = 0; t < 3000 && !idle; t++) begin
        @(negedge clock);
        idle = (busy === 1'b0) && (fifo_count === 3'd0);
      end
      chk("rnd_drain", 32'(idle), 32'd1);
      repeat (2) @(negedge clock);
      chk("rnd_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clock); #1;
    end
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
